munoc_rchannel_lane_buffer: RTL and testbench
=============================================

MUNOC_RCHANNEL_LANE_BUFFER -- requirements
Module: munoc_rchannel_lane_buffer

Interface
REQ-001 SHALL have parameter BW_TID, default 4, R-channel transaction-ID width.
REQ-002 SHALL have parameter LANE_WIDTH, default 32, bits per data lane (8, 16 or 32).
REQ-003 SHALL have parameter NUM_LANE, default 4, data lanes; BW_DATA = NUM_LANE*LANE_WIDTH, power of two, 32..512.
REQ-004 SHALL have parameter DEPTH, default 2, entries per FIFO (1..16, non-power-of-two allowed).
REQ-005 SHALL derive BW_HEAD = BW_TID+1+2 (id, last, resp) and BW_RCH = BW_HEAD+BW_DATA, header in MSBs, lane i at bits [(i+1)*LANE_WIDTH-1 -: LANE_WIDTH].
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 wvalid  input  1  incoming R beat valid.
REQ-009 wready  output  1  beat accepted when wvalid&&wready.
REQ-010 wlane_mask  input  NUM_LANE  lanes carried by incoming beat.
REQ-011 wdata  input  BW_RCH  incoming beat (header+lanes).
REQ-012 rsize  input  3  AXI size code of outgoing beat (2=32b ... 6=512b).
REQ-013 rvalid  output  1  outgoing beat available.
REQ-014 rready  input  1  outgoing beat consumed when rvalid&&rready.
REQ-015 rdata  output  BW_RCH  outgoing beat.
REQ-016 count  output  clog2(DEPTH+1)  header-FIFO occupancy.
REQ-017 size_error  output  1  sticky: rsize requested more than BW_DATA.

Function
REQ-018 SHALL hold one header FIFO and NUM_LANE independent lane FIFOs, each DEPTH deep, read/write pointers wrapping DEPTH-1 -> 0.
REQ-019 wready SHALL be 1 iff header FIFO not full and every lane FIFO selected by wlane_mask not full; derived from registered state only, never from rready.
REQ-020 On accept, header SHALL be pushed and only lanes with wlane_mask=1 pushed; unmasked lanes unchanged.
REQ-021 Lanes popped per beat N = (8<<rsize)/LANE_WIDTH, minimum 1; N>NUM_LANE or rsize<2 is invalid.
REQ-022 rvalid SHALL be 1 iff header FIFO non-empty, rsize valid, and lane FIFOs 0..N-1 all non-empty.
REQ-023 On rvalid&&rready, header and lanes 0..N-1 SHALL pop in the same cycle.
REQ-024 rdata SHALL present oldest header and oldest entries of lanes 0..N-1; lanes N..NUM_LANE-1 SHALL read as zero.
REQ-025 Invalid rsize SHALL force rvalid=0 and set size_error on the clock edge where header FIFO is non-empty; size_error stays 1 until reset.
REQ-026 Simultaneous push and pop on any FIFO SHALL be allowed when not full; occupancy unchanged; full FIFO never accepts same-cycle push on pop.
REQ-027 count SHALL increment on header push, decrement on header pop, hold on both; range 0..DEPTH.
REQ-028 Latency write-accept to rvalid SHALL be exactly 1 cycle (without bypass).
REQ-029 rvalid, once asserted, SHALL not deassert until popped, provided rsize held stable (rsize SHALL be stable while rvalid=1).

Reset
REQ-030 While rst=1: all pointers and occupancies 0, count=0, rvalid=0, wready=0, size_error=0, rdata=0.
REQ-031 First rising clk edge after rst deasserts SHALL see wready=1.
REQ-032 rst asserted mid-transfer SHALL discard all stored beats immediately, no partial pop.

Configuration
REQ-033 Macro MUNOC_RBUF_BYPASS_EN: when defined, if header FIFO and lane FIFOs 0..N-1 are empty and wlane_mask covers lanes 0..N-1, the incoming beat SHALL appear on rdata with rvalid=wvalid in the same cycle; wready=1; if rready=1 nothing is stored, else beat is stored normally.
REQ-034 Without MUNOC_RBUF_BYPASS_EN: no combinational wdata->rdata or wvalid->rvalid path; REQ-028 latency applies.

Verification
REQ-035 Defaults, rsize=4, write 2 beats mask 1111 id=3/5, rready=0 -> count=2, wready=0; third wvalid stalls; rready=1 pops id=3 then id=5, count 2->1->0.
REQ-036 rsize=2, write mask 0001 data lane0=0xA5A5A5A5 -> next cycle rvalid=1, rdata lane0=0xA5A5A5A5, lanes1-3=0, last/resp preserved.
REQ-037 DEPTH=3, continuous wvalid/rready with 1-cycle rready gaps for 20 beats -> all 20 emerged in order, pointers wrapped, count never >3.
REQ-038 NUM_LANE=4, LANE_WIDTH=32, rsize=5 with one stored beat -> rvalid=0, size_error=1 next edge, stays 1 until rst.
REQ-039 rst pulse while count=2 -> rvalid=0, count=0, wready=0 during reset, wready=1 after; old beats never appear.
REQ-040 With MUNOC_RBUF_BYPASS_EN, empty buffer, wvalid=1, rready=1 -> rvalid=1 same cycle, count stays 0; without macro -> rvalid next cycle, count=1 then 0.

Source files
------------

// File: rtl/munoc_rchannel_lane_buffer.sv
// R-channel beat buffer: one header FIFO plus NUM_LANE independent lane FIFOs; the outgoing beat pops lanes 0..N-1 by rsize.
// Optional same-cycle pass-through when empty is enabled with the MUNOC_RBUF_BYPASS_EN macro.
module munoc_rchannel_lane_buffer #(
    parameter  int BW_TID     = 4,
    parameter  int LANE_WIDTH = 32,
    parameter  int NUM_LANE   = 4,
    parameter  int DEPTH      = 2,
    localparam int BW_DATA    = NUM_LANE * LANE_WIDTH,
    localparam int BW_HEAD    = BW_TID + 1 + 2,
    localparam int BW_RCH     = BW_HEAD + BW_DATA
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [NUM_LANE-1:0]          wlane_mask,
    input  logic [BW_RCH-1:0]            wdata,
    input  logic [2:0]                   rsize,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [BW_RCH-1:0]            rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         size_error
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return c + 1'b1;
            2'b01:   return c - 1'b1;
            default: return c;
        endcase
    endfunction

    int                  n_lanes;
    logic                size_ok;
    logic [NUM_LANE-1:0] lane_sel;

    always_comb begin
        n_lanes = (8 << rsize) / LANE_WIDTH;
        if (n_lanes < 1) n_lanes = 1;
        size_ok = (rsize >= 3'd2) && (n_lanes <= NUM_LANE);
        for (int i = 0; i < NUM_LANE; i++) lane_sel[i] = (i < n_lanes);
    end

    logic [BW_HEAD-1:0] hdr_mem [DEPTH];
    logic [PW-1:0]      hdr_wr_q, hdr_wr_d, hdr_rd_q, hdr_rd_d;
    logic [CW-1:0]      hdr_cnt_q, hdr_cnt_d;
    logic               hdr_push, hdr_pop, hdr_full, hdr_empty;
    logic               size_error_q, size_error_d;

    assign hdr_full     = (hdr_cnt_q == CNT_FULL);
    assign hdr_empty    = (hdr_cnt_q == '0);
    assign hdr_wr_d     = hdr_push ? ptr_inc(hdr_wr_q) : hdr_wr_q;
    assign hdr_rd_d     = hdr_pop ? ptr_inc(hdr_rd_q) : hdr_rd_q;
    assign hdr_cnt_d    = cnt_next(hdr_cnt_q, hdr_push, hdr_pop);
    assign size_error_d = size_error_q | (!hdr_empty && !size_ok);

    always_ff @(posedge clk) begin
        if (hdr_push) hdr_mem[hdr_wr_q] <= wdata[BW_RCH-1 -: BW_HEAD];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_wr_q     <= '0;
            hdr_rd_q     <= '0;
            hdr_cnt_q    <= '0;
            size_error_q <= 1'b0;
        end else begin
            hdr_wr_q     <= hdr_wr_d;
            hdr_rd_q     <= hdr_rd_d;
            hdr_cnt_q    <= hdr_cnt_d;
            size_error_q <= size_error_d;
        end
    end

    logic [NUM_LANE-1:0] lane_full, lane_empty, lane_push, lane_pop;
    logic [BW_DATA-1:0]  lane_head, sel_mask;

    for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_lane
        logic [LANE_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0]         cnt_q, cnt_d;

        assign wr_d  = lane_push[gi] ? ptr_inc(wr_q) : wr_q;
        assign rd_d  = lane_pop[gi] ? ptr_inc(rd_q) : rd_q;
        assign cnt_d = cnt_next(cnt_q, lane_push[gi], lane_pop[gi]);

        always_ff @(posedge clk) begin
            if (lane_push[gi]) mem[wr_q] <= wdata[gi*LANE_WIDTH +: LANE_WIDTH];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
            end
        end

        assign lane_full[gi]  = (cnt_q == CNT_FULL);
        assign lane_empty[gi] = (cnt_q == '0);
        assign lane_head[gi*LANE_WIDTH +: LANE_WIDTH] = mem[rd_q];
        assign sel_mask[gi*LANE_WIDTH +: LANE_WIDTH]  = {LANE_WIDTH{lane_sel[gi]}};
    end

    logic stored_valid, store_ready;

    // Only lanes this beat actually carries gate acceptance; the others may be full.
    assign stored_valid = !hdr_empty && size_ok && (&(~lane_empty | ~lane_sel));
    assign store_ready  = !hdr_full && !(|(wlane_mask & lane_full));
    assign hdr_pop      = stored_valid && rready;
    assign lane_push    = {NUM_LANE{hdr_push}} & wlane_mask;
    assign lane_pop     = {NUM_LANE{hdr_pop}} & lane_sel;

`ifdef MUNOC_RBUF_BYPASS_EN
    logic bypass_ok;

    assign bypass_ok = hdr_empty && size_ok && (&(lane_empty | ~lane_sel)) && (&(wlane_mask | ~lane_sel));
    assign wready    = !rst && (store_ready || bypass_ok);
    assign rvalid    = !rst && (stored_valid || (bypass_ok && wvalid));
    assign hdr_push  = wvalid && wready && !(bypass_ok && rready);

    always_comb begin
        rdata = '0;
        if (!rst && stored_valid)
            rdata = {hdr_mem[hdr_rd_q], lane_head & sel_mask};
        else if (!rst && bypass_ok && wvalid)
            rdata = {wdata[BW_RCH-1 -: BW_HEAD], wdata[BW_DATA-1:0] & sel_mask};
    end
`else
    assign wready   = !rst && store_ready;
    assign rvalid   = !rst && stored_valid;
    assign hdr_push = wvalid && wready;
    assign rdata    = rvalid ? {hdr_mem[hdr_rd_q], lane_head & sel_mask} : '0;
`endif

    assign count      = hdr_cnt_q;
    assign size_error = size_error_q;

endmodule

// File: tb/tb_munoc_rchannel_lane_buffer.sv
// Randomised bench for munoc_rchannel_lane_buffer against a queue-based reference model (default build, no bypass).
`timescale 1ns/1ps
module tb_munoc_rchannel_lane_buffer;

    localparam int BW_TID  = 4;
    localparam int LW      = 32;
    localparam int NL      = 4;
    localparam int DEPTH   = 3;
    localparam int BW_HEAD = BW_TID + 3;
    localparam int BW_DATA = NL * LW;
    localparam int BW_RCH  = BW_HEAD + BW_DATA;
    localparam int CW      = $clog2(DEPTH + 1);

    logic              clk, rst, wvalid, wready, rvalid, rready, size_error;
    logic [NL-1:0]     wlane_mask;
    logic [BW_RCH-1:0] wdata, rdata;
    logic [2:0]        rsize;
    logic [CW-1:0]     count;

    munoc_rchannel_lane_buffer #(
        .BW_TID(BW_TID), .LANE_WIDTH(LW), .NUM_LANE(NL), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .wvalid(wvalid), .wready(wready), .wlane_mask(wlane_mask),
        .wdata(wdata), .rsize(rsize), .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .count(count), .size_error(size_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one header queue and one data queue per lane.
    logic [BW_HEAD-1:0] mh[$];
    logic [LW-1:0]      lq0[$], lq1[$], lq2[$], lq3[$];
    bit                 msize_err;
    logic               exp_wready, exp_rvalid, exp_serr;
    logic [BW_RCH-1:0]  exp_rdata;
    int                 exp_count;

    function automatic int nl_of(input logic [2:0] s);
        int n = (8 << s) / LW;
        return (n < 1) ? 1 : n;
    endfunction

    function automatic bit sz_ok(input logic [2:0] s);
        return (s >= 3'd2) && (nl_of(s) <= NL);
    endfunction

    function automatic int lsize(input int i);
        case (i)
            0: return lq0.size();
            1: return lq1.size();
            2: return lq2.size();
            default: return lq3.size();
        endcase
    endfunction

    function automatic logic [LW-1:0] lfront(input int i);
        case (i)
            0: return lq0[0];
            1: return lq1[0];
            2: return lq2[0];
            default: return lq3[0];
        endcase
    endfunction

    function automatic void lpush(input int i, input logic [LW-1:0] d);
        case (i)
            0: lq0.push_back(d);
            1: lq1.push_back(d);
            2: lq2.push_back(d);
            default: lq3.push_back(d);
        endcase
    endfunction

    function automatic void lpop(input int i);
        case (i)
            0: void'(lq0.pop_front());
            1: void'(lq1.pop_front());
            2: void'(lq2.pop_front());
            default: void'(lq3.pop_front());
        endcase
    endfunction

    function automatic void model_clear();
        mh.delete(); lq0.delete(); lq1.delete(); lq2.delete(); lq3.delete();
        msize_err = 0;
    endfunction

    function automatic void model_eval();
        int n = nl_of(rsize);
        exp_wready = !rst && (mh.size() < DEPTH);
        for (int i = 0; i < NL; i++)
            if (wlane_mask[i] && lsize(i) >= DEPTH) exp_wready = 1'b0;
        exp_rvalid = !rst && (mh.size() > 0) && sz_ok(rsize);
        if (exp_rvalid)
            for (int i = 0; i < n; i++) if (lsize(i) == 0) exp_rvalid = 1'b0;
        exp_rdata = '0;
        if (exp_rvalid) begin
            exp_rdata[BW_RCH-1 -: BW_HEAD] = mh[0];
            for (int i = 0; i < n; i++) exp_rdata[i*LW +: LW] = lfront(i);
        end
        exp_count = mh.size();
        exp_serr  = msize_err;
    endfunction

    // Advance one clock and apply the handshakes the model predicts.
    task automatic tick();
        int n;
        bit acc, pp, se;
        logic [BW_RCH-1:0]  wd;
        logic [NL-1:0]      m;
        logic [BW_HEAD-1:0] h;
        model_eval();
        n   = nl_of(rsize);
        acc = wvalid && exp_wready;
        pp  = exp_rvalid && rready;
        se  = (mh.size() > 0) && !sz_ok(rsize);
        wd  = wdata;
        m   = wlane_mask;
        @(posedge clk); #1;
        if (se) msize_err = 1;
        if (pp) begin
            h = mh[0];
            $display("pop  id=%0h hdr=%h", h[BW_HEAD-1 -: BW_TID], h);
            void'(mh.pop_front());
            for (int i = 0; i < n; i++) lpop(i);
        end
        if (acc) begin
            $display("push id=%0h mask=%b", wd[BW_RCH-1 -: BW_TID], m);
            mh.push_back(wd[BW_RCH-1 -: BW_HEAD]);
            for (int i = 0; i < NL; i++) if (m[i]) lpush(i, wd[i*LW +: LW]);
        end
    endtask

    function automatic logic [BW_RCH-1:0] make_beat(input logic [BW_TID-1:0] id, input logic last, input logic [1:0] resp);
        logic [BW_RCH-1:0] b;
        b[BW_RCH-1 -: BW_HEAD] = {id, last, resp};
        for (int i = 0; i < NL; i++) b[i*LW +: LW] = $urandom;
        return b;
    endfunction

    task automatic rst_pulse();
        rst = 1'b1; wvalid = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; wvalid = 1'b0; rready = 1'b0; rsize = 3'd4; wlane_mask = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1; model_clear();
        total++; if (wready !== 1'b0) begin bad++; $display("FAIL reset_wready got=%b exp=0", wready); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (size_error !== 1'b0) begin bad++; $display("FAIL reset_size_error got=%b exp=0", size_error); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        rst = 1'b0; #2;
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL reset_release_wready got=%b exp=1", wready); end
        @(posedge clk); #1;
    endtask

    task automatic test_fill_stall();
        logic [BW_TID-1:0] id;
        rsize = 3'd4; rready = 1'b0; wlane_mask = 4'hF;
        for (int k = 0; k <= DEPTH + 1; k++) begin
            id = (k == 0) ? 4'd3 : (k == 1) ? 4'd5 : BW_TID'(2 * k + 3);
            wvalid = 1'b1; wdata = make_beat(id, 1'b1, 2'b00);
            #2; model_eval();
            total++; if (wready !== exp_wready) begin bad++; $display("FAIL fill_wready k=%0d got=%b exp=%b", k, wready, exp_wready); end
            total++; if (int'(count) !== exp_count) begin bad++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count, exp_count); end
            tick();
        end
        wvalid = 1'b0; rready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #2; model_eval();
            total++; if (rvalid !== exp_rvalid || (exp_rvalid && rdata !== exp_rdata))
                begin bad++; $display("FAIL drain_beat k=%0d rvalid=%b rdata=%h exp_rvalid=%b exp_rdata=%h", k, rvalid, rdata, exp_rvalid, exp_rdata); end
            if (k < 2) begin
                total++; if (rdata[BW_RCH-1 -: BW_TID] !== ((k == 0) ? 4'd3 : 4'd5))
                    begin bad++; $display("FAIL drain_id k=%0d got=%0d exp=%0d", k, rdata[BW_RCH-1 -: BW_TID], (k == 0) ? 3 : 5); end
            end
            total++; if (int'(count) !== DEPTH - k) begin bad++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, count, DEPTH - k); end
            tick();
        end
        #2;
        total++; if (count !== '0 || rvalid !== 1'b0) begin bad++; $display("FAIL drain_empty count=%0d rvalid=%b exp 0/0", count, rvalid); end
        rready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_narrow_lane();
        logic [BW_RCH-1:0] b;
        rsize = 3'd2; rready = 1'b0; wvalid = 1'b1; wlane_mask = 4'b0001;
        b = make_beat(4'd6, 1'b1, 2'b10);
        b[31:0] = 32'hA5A5A5A5;
        wdata = b;
        #2; model_eval();
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL narrow_same_cycle_rvalid got=%b exp=0", rvalid); end
        tick();
        wvalid = 1'b0; #2; model_eval();
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL narrow_rvalid got=%b exp=1", rvalid); end
        total++; if (rdata[31:0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL narrow_lane0 got=%h exp=a5a5a5a5", rdata[31:0]); end
        total++; if (rdata[BW_DATA-1:32] !== '0) begin bad++; $display("FAIL narrow_upper_lanes got=%h exp=0", rdata[BW_DATA-1:32]); end
        total++; if (rdata[BW_RCH-1 -: BW_HEAD] !== {4'd6, 1'b1, 2'b10}) begin bad++; $display("FAIL narrow_header got=%h exp=%h", rdata[BW_RCH-1 -: BW_HEAD], {4'd6, 1'b1, 2'b10}); end
        rready = 1'b1; tick();
        #2;
        total++; if (count !== '0) begin bad++; $display("FAIL narrow_pop_count got=%0d exp=0", count); end
        rready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int sent = 0, popped = 0, cyc = 0;
        rsize = 3'd4; wlane_mask = 4'hF;
        wdata = make_beat(BW_TID'(0), 1'b0, 2'b01);
        while (popped < 20 && cyc < 200) begin
            wvalid = (sent < 20);
            rready = (cyc % 3 != 2);
            #2; model_eval();
            total++; if (wready !== exp_wready) begin bad++; $display("FAIL b2b_wready cyc=%0d got=%b exp=%b", cyc, wready, exp_wready); end
            total++; if (rvalid !== exp_rvalid) begin bad++; $display("FAIL b2b_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); end
            total++; if (int'(count) > DEPTH) begin bad++; $display("FAIL b2b_count_max cyc=%0d got=%0d max=%0d", cyc, count, DEPTH); end
            if (exp_rvalid) begin
                total++; if (rdata !== exp_rdata || rdata[BW_RCH-1 -: BW_TID] !== BW_TID'(popped))
                    begin bad++; $display("FAIL b2b_order beat=%0d got=%h exp=%h", popped, rdata, exp_rdata); end
                if (rready) popped++;
            end
            if (wvalid && exp_wready) begin
                sent++;
                tick();
                wdata = make_beat(BW_TID'(sent), (sent == 19), 2'b01);
            end else tick();
            cyc++;
        end
        total++; if (popped != 20) begin bad++; $display("FAIL b2b_timeout popped=%0d exp=20", popped); end
        wvalid = 1'b0; rready = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] sizes [3];
        sizes[0] = 3'd2; sizes[1] = 3'd3; sizes[2] = 3'd4;
        for (int seg = 0; seg < 3; seg++) begin
            rst_pulse();
            rsize = sizes[seg];
            for (int c = 0; c < 60; c++) begin
                wvalid = $urandom_range(0, 1);
                rready = $urandom_range(0, 3) != 0;
                wlane_mask = ($urandom_range(0, 1) == 1) ? 4'hF : NL'($urandom);
                wdata = make_beat(BW_TID'($urandom), 1'($urandom), 2'($urandom));
                #2; model_eval();
                total++; if (wready !== exp_wready) begin bad++; $display("FAIL rand_wready seg=%0d c=%0d got=%b exp=%b", seg, c, wready, exp_wready); end
                total++; if (rvalid !== exp_rvalid) begin bad++; $display("FAIL rand_rvalid seg=%0d c=%0d got=%b exp=%b", seg, c, rvalid, exp_rvalid); end
                total++; if (int'(count) !== exp_count) begin bad++; $display("FAIL rand_count seg=%0d c=%0d got=%0d exp=%0d", seg, c, count, exp_count); end
                if (exp_rvalid) begin
                    total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL rand_rdata seg=%0d c=%0d got=%h exp=%h", seg, c, rdata, exp_rdata); end
                end
                tick();
            end
        end
        wvalid = 1'b0; rready = 1'b0;
    endtask

    task automatic test_size_error();
        rst_pulse();
        rsize = 3'd5; wvalid = 1'b1; wlane_mask = 4'hF; wdata = make_beat(4'd9, 1'b1, 2'b00);
        tick();
        wvalid = 1'b0; #2; model_eval();
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL size_rvalid got=%b exp=0", rvalid); end
        total++; if (size_error !== 1'b0) begin bad++; $display("FAIL size_err_before_edge got=%b exp=0", size_error); end
        tick();
        #2;
        total++; if (size_error !== 1'b1) begin bad++; $display("FAIL size_err_set got=%b exp=1", size_error); end
        rsize = 3'd4; rready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2; model_eval();
            total++; if (size_error !== exp_serr || rvalid !== exp_rvalid)
                begin bad++; $display("FAIL size_err_sticky c=%0d got=%b/%b exp=%b/%b", c, size_error, rvalid, exp_serr, exp_rvalid); end
            tick();
        end
        rst_pulse(); #2;
        total++; if (size_error !== 1'b0) begin bad++; $display("FAIL size_err_clear got=%b exp=0", size_error); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        rst_pulse();
        rsize = 3'd4; rready = 1'b0; wlane_mask = 4'hF;
        for (int k = 0; k < 2; k++) begin
            wvalid = 1'b1; wdata = make_beat(BW_TID'(10 + k), 1'b0, 2'b00);
            tick();
        end
        wvalid = 1'b0; #2;
        total++; if (count !== CW'(2)) begin bad++; $display("FAIL mid_count_before got=%0d exp=2", count); end
        rst = 1'b1; #1;
        model_clear();
        total++; if (rvalid !== 1'b0 || count !== '0 || wready !== 1'b0 || rdata !== '0)
            begin bad++; $display("FAIL mid_reset_state rvalid=%b count=%0d wready=%b rdata=%h exp all 0", rvalid, count, wready, rdata); end
        @(posedge clk); #1;
        rst = 1'b0; rready = 1'b1; #2;
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL mid_release_wready got=%b exp=1", wready); end
        for (int c = 0; c < 3; c++) begin
            total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL mid_stale_beat c=%0d rvalid=%b exp=0", c, rvalid); end
            tick(); #2;
        end
        wvalid = 1'b1; wdata = make_beat(4'd12, 1'b1, 2'b11);
        tick();
        wvalid = 1'b0; #2;
        total++; if (rvalid !== 1'b1 || rdata[BW_RCH-1 -: BW_TID] !== 4'd12)
            begin bad++; $display("FAIL mid_new_beat rvalid=%b id=%0d exp 1/12", rvalid, rdata[BW_RCH-1 -: BW_TID]); end
        tick();
        rready = 1'b0;
    endtask

    task automatic test_latency();
        rst_pulse();
        rsize = 3'd4; wlane_mask = 4'hF; wvalid = 1'b1; rready = 1'b1;
        wdata = make_beat(4'd7, 1'b1, 2'b00);
        #2;
        total++; if (rvalid !== 1'b0 || wready !== 1'b1 || count !== '0)
            begin bad++; $display("FAIL lat_cycle0 rvalid=%b wready=%b count=%0d exp 0/1/0", rvalid, wready, count); end
        tick();
        wvalid = 1'b0; #2;
        total++; if (rvalid !== 1'b1 || count !== CW'(1))
            begin bad++; $display("FAIL lat_cycle1 rvalid=%b count=%0d exp 1/1", rvalid, count); end
        tick(); #2;
        total++; if (rvalid !== 1'b0 || count !== '0)
            begin bad++; $display("FAIL lat_cycle2 rvalid=%b count=%0d exp 0/0", rvalid, count); end
        rready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill_stall();
        test_narrow_lane();
        test_back_to_back();
        test_random();
        test_size_error();
        test_reset_mid();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
